ptb2_axi4_lite_regfile: RTL and testbench

Parametrised AXI4-Lite slave register file, the successor to the fixed single-register PTB2 slave. It provides C_NUM_REG word-wide registers: the low ones are read/write control registers, the top C_NUM_RO are read-only status registers. It supports byte strobes and returns SLVERR for illegal accesses. It sits directly under the PTB2 IP top level and presents control registers and per-register write pulses to user logic.

---
 rtl/ptb2_axi_pkg.sv | 13 +
 rtl/ptb2_strb_merge.sv | 13 +
 rtl/ptb2_axi4_lite_regfile.sv | 186 ++++++++++++++++++
 tb/tb_ptb2_axi4_lite_regfile.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ptb2_axi_pkg.sv
// ptb2_axi_pkg: shared AXI4-Lite response codes, channel state encodings and width helper
package ptb2_axi_pkg;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/ptb2_strb_merge.sv
// ptb2_strb_merge: byte-lane merge of old and new data under a write strobe
module ptb2_strb_merge #(
  parameter int DW = 32
) (
  input  logic [DW-1:0]   old_i,
  input  logic [DW-1:0]   new_i,
  input  logic [DW/8-1:0] strb_i,
  output logic [DW-1:0]   data_o
);
  for (genvar b = 0; b < DW / 8; b++) begin : g_lane
    assign data_o[b*8 +: 8] = strb_i[b] ? new_i[b*8 +: 8] : old_i[b*8 +: 8];
  end
endmodule

// File: rtl/ptb2_axi4_lite_regfile.sv
// ptb2_axi4_lite_regfile: AXI4-Lite slave with RW control registers and RO status registers
module ptb2_axi4_lite_regfile
  import ptb2_axi_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_NUM_REG = 8,
  parameter int C_NUM_RO = 2,
  parameter int C_USE_WSTRB = 1
) (
  input  logic                                                  S_AXI_ACLK,
  input  logic                                                  S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]                         S_AXI_AWADDR,
  input  logic                                                  S_AXI_AWVALID,
  output logic                                                  S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]                         S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]                       S_AXI_WSTRB,
  input  logic                                                  S_AXI_WVALID,
  output logic                                                  S_AXI_WREADY,
  output logic [1:0]                                            S_AXI_BRESP,
  output logic                                                  S_AXI_BVALID,
  input  logic                                                  S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]                         S_AXI_ARADDR,
  input  logic                                                  S_AXI_ARVALID,
  output logic                                                  S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]                         S_AXI_RDATA,
  output logic [1:0]                                            S_AXI_RRESP,
  output logic                                                  S_AXI_RVALID,
  input  logic                                                  S_AXI_RREADY,
  output logic [C_NUM_REG*C_S_AXI_DATA_WIDTH-1:0]               REG_OUT,
  output logic [C_NUM_REG-1:0]                                  REG_WR_PULSE,
  input  logic [(C_NUM_RO > 0 ? C_NUM_RO : 1)*C_S_AXI_DATA_WIDTH-1:0] STATUS_IN
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = DW / 8;
  localparam int NUM_RW = C_NUM_REG - C_NUM_RO;
  localparam int ADDR_LSB = clog2(SW);
  // one bit wider than strictly needed whenever C_NUM_REG is a power of two, so that
  // indices just past the last register decode as out of range rather than aliasing
  localparam int IDX_W = clog2(C_NUM_REG + 1) > 1 ? clog2(C_NUM_REG + 1) : 1;
  localparam int NSLOT = 1 << IDX_W;

  logic live_q;
  w_state_e w_q, w_d;
  r_state_e r_q, r_d;
  logic aw_hold_q, aw_hold_d, w_hold_q, w_hold_d;
  logic [IDX_W-1:0] awidx_q, awidx_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [SW-1:0] wstrb_q, wstrb_d;
  logic [1:0] bresp_q, bresp_d, rresp_q, rresp_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [C_NUM_REG-1:0] pulse_q, pulse_d;
  logic [DW-1:0] regs_q [C_NUM_REG];
  logic [DW-1:0] slot [NSLOT];
  logic aw_hs, w_hs, ar_hs, go, w_ok;
  logic [IDX_W-1:0] w_idx, r_idx;
  logic [DW-1:0] w_data, merged;
  logic [SW-1:0] w_strb;
  logic unused_ok;

  assign unused_ok = &{1'b0, S_AXI_AWADDR, S_AXI_ARADDR, S_AXI_WSTRB, wstrb_q, STATUS_IN};

  for (genvar i = 0; i < NSLOT; i++) begin : g_slot
    if (i < NUM_RW) begin : g_rw
      assign slot[i] = regs_q[i];
    end else if (i < C_NUM_REG) begin : g_ro
      assign slot[i] = STATUS_IN[(i-NUM_RW)*DW +: DW];
    end else begin : g_nil
      assign slot[i] = '0;
    end
  end

  for (genvar i = 0; i < C_NUM_REG; i++) begin : g_out
    assign REG_OUT[i*DW +: DW] = regs_q[i];
  end

  assign S_AXI_AWREADY = live_q && w_q == W_IDLE && !aw_hold_q;
  assign S_AXI_WREADY = live_q && w_q == W_IDLE && !w_hold_q;
  assign S_AXI_BVALID = w_q == W_RESP;
  assign S_AXI_BRESP = bresp_q;
  assign S_AXI_ARREADY = live_q && r_q == R_IDLE;
  assign S_AXI_RVALID = r_q == R_DATA;
  assign S_AXI_RDATA = rdata_q;
  assign S_AXI_RRESP = rresp_q;
  assign REG_WR_PULSE = pulse_q;

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
  assign w_idx = aw_hold_q ? awidx_q : S_AXI_AWADDR[ADDR_LSB +: IDX_W];
  assign w_data = w_hold_q ? wdata_q : S_AXI_WDATA;
  assign w_strb = C_USE_WSTRB != 0 ? (w_hold_q ? wstrb_q : S_AXI_WSTRB) : '1;
  assign go = (aw_hold_q || aw_hs) && (w_hold_q || w_hs);
  assign w_ok = 32'(w_idx) < NUM_RW;
  assign r_idx = S_AXI_ARADDR[ADDR_LSB +: IDX_W];

  ptb2_strb_merge #(.DW(DW)) u_merge (
    .old_i  (slot[w_idx]),
    .new_i  (w_data),
    .strb_i (w_strb),
    .data_o (merged)
  );

  // write channel: capture AW and W independently, commit the moment both are present
  always_comb begin
    w_d = w_q;
    aw_hold_d = aw_hold_q;
    w_hold_d = w_hold_q;
    awidx_d = awidx_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    bresp_d = bresp_q;
    for (int i = 0; i < C_NUM_REG; i++) pulse_d[i] = go && w_ok && w_idx == IDX_W'(i);
    if (aw_hs) begin
      aw_hold_d = 1'b1;
      awidx_d = S_AXI_AWADDR[ADDR_LSB +: IDX_W];
    end
    if (w_hs) begin
      w_hold_d = 1'b1;
      wdata_d = S_AXI_WDATA;
      wstrb_d = S_AXI_WSTRB;
    end
    if (go) begin
      w_d = W_RESP;
      aw_hold_d = 1'b0;
      w_hold_d = 1'b0;
      bresp_d = w_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (w_q == W_RESP && S_AXI_BREADY) begin
      w_d = W_IDLE;
    end
  end

  // write-side state and register storage; RO slots are never written and stay zero
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      live_q <= 1'b0;
      w_q <= W_IDLE;
      aw_hold_q <= 1'b0;
      w_hold_q <= 1'b0;
      awidx_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      bresp_q <= RESP_OKAY;
      pulse_q <= '0;
      for (int i = 0; i < C_NUM_REG; i++) regs_q[i] <= '0;
    end else begin
      live_q <= 1'b1;
      w_q <= w_d;
      aw_hold_q <= aw_hold_d;
      w_hold_q <= w_hold_d;
      awidx_q <= awidx_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      bresp_q <= bresp_d;
      pulse_q <= pulse_d;
      for (int i = 0; i < NUM_RW; i++) if (pulse_d[i]) regs_q[i] <= merged;
    end
  end

  // read channel: sample register or status slot at the AR handshake, hold until RREADY
  always_comb begin
    r_d = r_q;
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    if (ar_hs) begin
      r_d = R_DATA;
      rdata_d = slot[r_idx];
      rresp_d = 32'(r_idx) < C_NUM_REG ? RESP_OKAY : RESP_SLVERR;
    end else if (r_q == R_DATA && S_AXI_RREADY) begin
      r_d = R_IDLE;
    end
  end

  // read-side state register
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      r_q <= R_IDLE;
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else begin
      r_q <= r_d;
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
    end
  end
endmodule

// File: tb/tb_ptb2_axi4_lite_regfile.sv
// tb_ptb2_axi4_lite_regfile: directed table-driven bench for the AXI4-Lite register file
module tb_ptb2_axi4_lite_regfile;
  localparam logic [1:0] OK = 2'b00;
  localparam logic [1:0] ERR = 2'b10;

  logic clk = 1'b0;
  logic rst;
  logic [31:0] aw_addr, wdata, ar_addr;
  logic [3:0] wstrb;
  logic awvalid, wvalid, bready, arvalid, rready;
  logic awready, wready, bvalid, arready, rvalid;
  logic [1:0] bresp, rresp;
  logic [31:0] rdata;
  logic [255:0] reg_out;
  logic [7:0] reg_wr_pulse;
  logic [63:0] status_in;
  logic n_awready, n_wready, n_bvalid, n_arready, n_rvalid;
  logic [1:0] n_bresp, n_rresp;
  logic [31:0] n_rdata;
  logic [255:0] n_reg_out;
  logic [7:0] n_reg_wr_pulse;
  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ptb2_axi4_lite_regfile dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
    .S_AXI_AWADDR(aw_addr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(ar_addr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .REG_OUT(reg_out), .REG_WR_PULSE(reg_wr_pulse), .STATUS_IN(status_in)
  );

  ptb2_axi4_lite_regfile #(.C_USE_WSTRB(0)) dut_nostrb (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
    .S_AXI_AWADDR(aw_addr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(n_awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(n_wready),
    .S_AXI_BRESP(n_bresp), .S_AXI_BVALID(n_bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(ar_addr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(n_arready),
    .S_AXI_RDATA(n_rdata), .S_AXI_RRESP(n_rresp), .S_AXI_RVALID(n_rvalid), .S_AXI_RREADY(rready),
    .REG_OUT(n_reg_out), .REG_WR_PULSE(n_reg_wr_pulse), .STATUS_IN(status_in)
  );

  typedef struct {
    bit wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0] strb;
    int aw_dly;
    int w_dly;
    int idx;
    logic [1:0] resp;
    logic [31:0] exp;
    logic [7:0] pulse;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, output logic [1:0] resp, output logic [7:0] pulse);
    bit aw_done, w_done, early, ha, hw;
    aw_done = 0;
    w_done = 0;
    early = 0;
    aw_addr = addr;
    wdata = data;
    wstrb = strb;
    for (int c = 0; c < 40 && !(aw_done && w_done); c++) begin
      awvalid = !aw_done && c >= aw_dly;
      wvalid = !w_done && c >= w_dly;
      ha = awvalid && awready;
      hw = wvalid && wready;
      early |= bvalid || reg_wr_pulse != 8'h00;
      tick();
      aw_done |= ha;
      w_done |= hw;
    end
    awvalid = 0;
    wvalid = 0;
    check("aw_w_handshake", 64'(aw_done && w_done), 64'd1);
    check("no_early_commit", 64'(early), 64'd0);
    check("bvalid_latency", 64'(bvalid), 64'd1);
    resp = bresp;
    pulse = reg_wr_pulse;
    bready = 1;
    tick();
    bready = 0;
    check("pulse_one_cycle", 64'(reg_wr_pulse), 64'd0);
    check("bvalid_drop", 64'(bvalid), 64'd0);
  endtask

  task automatic do_read(input logic [31:0] addr, input int rdly, output logic [31:0] data, output logic [1:0] resp);
    bit done, stable;
    done = 0;
    stable = 1;
    ar_addr = addr;
    arvalid = 1;
    for (int c = 0; c < 40 && !done; c++) begin
      done = arready;
      tick();
    end
    arvalid = 0;
    check("ar_handshake", 64'(done), 64'd1);
    check("rvalid_latency", 64'(rvalid), 64'd1);
    data = rdata;
    resp = rresp;
    for (int k = 0; k < rdly; k++) begin
      tick();
      stable &= rvalid && rdata == data && rresp == resp;
    end
    if (rdly > 0) check("r_stable", 64'(stable), 64'd1);
    rready = 1;
    tick();
    rready = 0;
    check("rvalid_drop", 64'(rvalid), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, rd2;
    logic [1:0] rr, rr2, wr;
    logic [7:0] wp;
    vecs[0]  = '{1'b1, 32'h00000000, 32'hDEADBEEF, 4'hF, 0, 0, 0, OK,  32'hDEADBEEF, 8'h01};
    vecs[1]  = '{1'b1, 32'h00000004, 32'hFFFFFFFF, 4'h2, 0, 1, 1, OK,  32'h0000FF00, 8'h02};
    vecs[2]  = '{1'b1, 32'h00000008, 32'hAABBCCDD, 4'h5, 2, 0, 2, OK,  32'h00BB00DD, 8'h04};
    vecs[3]  = '{1'b1, 32'h00000018, 32'h00000001, 4'hF, 0, 0, 6, ERR, 32'h00000000, 8'h00};
    vecs[4]  = '{1'b1, 32'h00000024, 32'h00000002, 4'hF, 0, 0, 1, ERR, 32'h0000FF00, 8'h00};
    vecs[5]  = '{1'b1, 32'h0000003C, 32'h00000003, 4'hF, 1, 1, 7, ERR, 32'h00000000, 8'h00};
    vecs[6]  = '{1'b1, 32'hFFFFFF0F, 32'h0BADF00D, 4'hF, 0, 0, 3, OK,  32'h0BADF00D, 8'h08};
    vecs[7]  = '{1'b0, 32'h00000000, 32'h0, 4'h0, 0, 0, 0, OK,  32'hDEADBEEF, 8'h00};
    vecs[8]  = '{1'b0, 32'h00000004, 32'h0, 4'h0, 2, 0, 0, OK,  32'h0000FF00, 8'h00};
    vecs[9]  = '{1'b0, 32'h00000024, 32'h0, 4'h0, 0, 0, 0, ERR, 32'h00000000, 8'h00};
    vecs[10] = '{1'b0, 32'h00000018, 32'h0, 4'h0, 0, 0, 0, OK,  32'h11112222, 8'h00};
    vecs[11] = '{1'b0, 32'h00000020, 32'h0, 4'h0, 0, 0, 0, ERR, 32'h00000000, 8'h00};
    vecs[12] = '{1'b0, 32'h10000008, 32'h0, 4'h0, 1, 0, 0, OK,  32'h00BB00DD, 8'h00};
    vecs[13] = '{1'b0, 32'h0000000C, 32'h0, 4'h0, 0, 0, 0, OK,  32'h0BADF00D, 8'h00};

    rst = 1;
    {awvalid, wvalid, bready, arvalid, rready} = '0;
    aw_addr = '0;
    ar_addr = '0;
    wdata = '0;
    wstrb = '0;
    status_in = {32'hA5A5A5A5, 32'h11112222};
    tick();
    tick();
    check("rst_ready", 64'({awready, wready, arready}), 64'd0);
    check("rst_valid", 64'({bvalid, rvalid}), 64'd0);
    check("rst_resp", 64'({bresp, rresp}), 64'd0);
    check("rst_rdata", 64'(rdata), 64'd0);
    check("rst_reg_out", 64'(reg_out == '0), 64'd1);
    check("rst_pulse", 64'(reg_wr_pulse), 64'd0);
    rst = 0;
    tick();
    check("ready_after_rst", 64'({awready, wready, arready}), 64'h7);

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].wr) begin
        do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].aw_dly, vecs[i].w_dly, wr, wp);
        check($sformatf("v%0d_bresp", i), 64'(wr), 64'(vecs[i].resp));
        check($sformatf("v%0d_pulse", i), 64'(wp), 64'(vecs[i].pulse));
        check($sformatf("v%0d_reg_out", i), 64'(reg_out[vecs[i].idx*32 +: 32]), 64'(vecs[i].exp));
      end else begin
        do_read(vecs[i].addr, vecs[i].aw_dly, rd, rr);
        check($sformatf("v%0d_rresp", i), 64'(rr), 64'(vecs[i].resp));
        check($sformatf("v%0d_rdata", i), 64'(rd), 64'(vecs[i].exp));
      end
    end

    check("nostrb_reg1", 64'(n_reg_out[63:32]), 64'hFFFFFFFF);
    check("nostrb_reg2", 64'(n_reg_out[95:64]), 64'hAABBCCDD);

    do_write(32'h0C, 32'h12345678, 4'hF, 3, 0, wr, wp);
    check("late_aw_bresp", 64'(wr), 64'(OK));
    check("late_aw_pulse", 64'(wp), 64'h08);
    do_read(32'h0C, 0, rd, rr);
    check("late_aw_readback", 64'(rd), 64'h12345678);

    fork
      begin
        do_read(32'h1C, 4, rd, rr);
        check("status_rdata", 64'(rd), 64'hA5A5A5A5);
        check("status_rresp", 64'(rr), 64'(OK));
      end
      begin
        do_write(32'h00, 32'hCAFEF00D, 4'hF, 0, 0, wr, wp);
        check("concurrent_bresp", 64'(wr), 64'(OK));
        check("concurrent_pulse", 64'(wp), 64'h01);
      end
      begin
        tick();
        tick();
        status_in[63:32] = 32'h0;
      end
    join
    check("concurrent_reg0", 64'(reg_out[31:0]), 64'hCAFEF00D);

    fork
      do_read(32'h00, 0, rd2, rr2);
      do_write(32'h00, 32'h55555555, 4'hF, 0, 0, wr, wp);
    join
    check("same_reg_pre_write", 64'(rd2), 64'hCAFEF00D);
    check("same_reg_new_value", 64'(reg_out[31:0]), 64'h55555555);

    aw_addr = 32'h04;
    wdata = 32'h13572468;
    wstrb = 4'hF;
    ar_addr = 32'h00;
    awvalid = 1;
    wvalid = 1;
    arvalid = 1;
    tick();
    {awvalid, wvalid, arvalid} = '0;
    check("abort_pre_bvalid", 64'(bvalid), 64'd1);
    check("abort_pre_rvalid", 64'(rvalid), 64'd1);
    rst = 1;
    tick();
    check("abort_bvalid", 64'(bvalid), 64'd0);
    check("abort_rvalid", 64'(rvalid), 64'd0);
    check("abort_reg_out", 64'(reg_out == '0), 64'd1);
    check("abort_ready_low", 64'({awready, wready, arready}), 64'd0);
    rst = 0;
    tick();
    check("abort_ready_back", 64'({awready, wready, arready}), 64'h7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
